register_32: RTL and testbench



---
 rtl/register_32.sv | 38 +++
 tb/tb_register_32.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/register_32.sv
// register_32: general-purpose datapath register (GP regs, PC, IR, MAR, ...).
// Captures the shared bus value when regIn is high at a rising clock edge and
// drives the stored value continuously toward the bus multiplexer input.
// clr is a synchronous, active-high clear and takes priority over a load.
module register_32 #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             regIn,
  input  logic [WIDTH-1:0] busMuxOut,
  output logic [WIDTH-1:0] busMuxIn_in
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next-value selection: clear beats load, otherwise hold the stored value.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = RESET_VALUE;
    end else if (regIn) begin
      q_d = busMuxOut;
    end
  end

  // Storage element; all state changes happen on the rising edge only.
  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  // The output is the stored value only, so there is no combinational path
  // from busMuxOut or regIn to busMuxIn_in.
  assign busMuxIn_in = q_q;

endmodule

// File: tb/tb_register_32.sv
// tb_register_32: self-checking bench for register_32 (default parameters).
// Directed vector table, hand-written between-edge sequences, then random
// traffic checked against a behavioural model of the register.
module tb_register_32;

  localparam int W = 32;
  localparam logic [W-1:0] RST = '0;

  logic         clk;
  logic         clr;
  logic         regIn;
  logic [W-1:0] busMuxOut;
  logic [W-1:0] busMuxIn_in;

  int total;
  int bad;

  register_32 #(
    .WIDTH       (W),
    .RESET_VALUE (RST)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .regIn       (regIn),
    .busMuxOut   (busMuxOut),
    .busMuxIn_in (busMuxIn_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         clr;
    logic         ld;
    logic [W-1:0] bus;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Compare one observed value against the bench's expectation.
  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Present inputs, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic c, input logic l, input logic [W-1:0] b);
    clr       = c;
    regIn     = l;
    busMuxOut = b;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] model;
  logic [W-1:0] prev;
  logic         c_r;
  logic         l_r;
  logic [W-1:0] b_r;

  initial begin
    total     = 0;
    bad       = 0;
    clr       = 1'b0;
    regIn     = 1'b0;
    busMuxOut = '0;
    #1;

    // Directed table, taken from the intended register behaviour.
    vecs.push_back('{"reset",         1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000});
    vecs.push_back('{"load_5",        1'b0, 1'b1, 32'h0000_0005, 32'h0000_0005});
    vecs.push_back('{"hold_1",        1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0005});
    vecs.push_back('{"hold_2",        1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0005});
    vecs.push_back('{"hold_3",        1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0005});
    vecs.push_back('{"clear_after",   1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000});
    vecs.push_back('{"load_a5",       1'b0, 1'b1, 32'hA5A5_5A5A, 32'hA5A5_5A5A});
    vecs.push_back('{"prio_clr_ld",   1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{"after_prio_ld", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    vecs.push_back('{"clr_held_1",    1'b1, 1'b1, 32'h1111_1111, 32'h0000_0000});
    vecs.push_back('{"clr_held_2",    1'b1, 1'b0, 32'h2222_2222, 32'h0000_0000});
    vecs.push_back('{"clr_held_3",    1'b1, 1'b1, 32'h3333_3333, 32'h0000_0000});
    vecs.push_back('{"first_ld",      1'b0, 1'b1, 32'h8000_0001, 32'h8000_0001});
    vecs.push_back('{"load_12345678", 1'b0, 1'b1, 32'h1234_5678, 32'h1234_5678});

    foreach (vecs[i]) begin
      step(vecs[i].clr, vecs[i].ld, vecs[i].bus);
      check(vecs[i].name, busMuxIn_in, vecs[i].exp);
    end

    // clr pulse entirely between two edges must have no effect.
    regIn     = 1'b0;
    busMuxOut = 32'h0BAD_0BAD;
    #2 clr = 1'b1;
    #1 check("clr_mid_cycle_no_async", busMuxIn_in, 32'h1234_5678);
    #2 clr = 1'b0;
    @(posedge clk);
    #1 check("clr_pulse_between_edges", busMuxIn_in, 32'h1234_5678);

    // bus glitch while loading: only the value settled at the edge counts.
    regIn     = 1'b1;
    busMuxOut = 32'hFFFF_0000;
    #2 check("no_comb_path_bus", busMuxIn_in, 32'h1234_5678);
    busMuxOut = 32'h0000_FFFF;
    #2 busMuxOut = 32'hCAFE_F00D;
    @(posedge clk);
    #1 check("glitch_settled_capture", busMuxIn_in, 32'hCAFE_F00D);

    // regIn pulse between edges must not load.
    regIn     = 1'b0;
    busMuxOut = 32'h7777_7777;
    #2 regIn = 1'b1;
    #2 regIn = 1'b0;
    @(posedge clk);
    #1 check("regin_pulse_between_edges", busMuxIn_in, 32'hCAFE_F00D);

    // Random traffic against the model.
    model = 32'hCAFE_F00D;
    for (int n = 0; n < 300; n++) begin
      c_r  = ($urandom_range(0, 7) == 0);
      l_r  = $urandom_range(0, 1) == 1;
      b_r  = $urandom;
      prev = model;
      clr       = c_r;
      regIn     = l_r;
      busMuxOut = b_r;
      if (n % 16 == 0) begin
        #2 check($sformatf("rand_%0d_stable_mid", n), busMuxIn_in, prev);
      end
      @(posedge clk);
      if (c_r) model = RST;
      else if (l_r) model = b_r;
      #1 check($sformatf("rand_%0d c=%0b l=%0b b=%08h", n, c_r, l_r, b_r),
               busMuxIn_in, model);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
